packet_scheduler: RTL and testbench

//  Next-gen HDMI data-island packet chooser. Once per packet slot it picks one of: ACR, audio sample, N InfoFrames, or null.

---
 rtl/hdmi_packet_pkg.sv | 23 ++
 rtl/audio_sample_fifo.sv | 54 +++++
 rtl/packet_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_packet_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// Packet type codes, ASP payload type and samples-per-packet helper shared by the HDMI packet scheduler.
package hdmi_packet_pkg;

   localparam logic [7:0] PKT_NULL     = 8'h00;
   localparam logic [7:0] PKT_ACR      = 8'h01;
   localparam logic [7:0] PKT_ASP      = 8'h02;
   localparam logic [7:0] PKT_EMP      = 8'h7F;
   localparam logic [7:0] PKT_VSIF     = 8'h81;
   localparam logic [7:0] PKT_AVI      = 8'h82;
   localparam logic [7:0] PKT_SPD      = 8'h83;
   localparam logic [7:0] PKT_AUDIO_IF = 8'h84;

   typedef logic [191:0] asp_payload_t;

   // Sample frames carried by one audio sample packet: layout 0 packs 4, layout 1 packs 1.
   function automatic int spp_f(input int channels);
      int spp;
      if (channels == 8) spp = 1;
      else spp = 4;
      return spp;
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock audio frame FIFO: pushes one frame per cycle, pops POP_FRAMES frames at once.
module audio_sample_fifo #(
   parameter int FRAME_WIDTH = 32,
   parameter int DEPTH       = 8,
   parameter int POP_FRAMES  = 4
) (
   input  logic                              clk_pixel,
   input  logic                              reset,
   input  logic                              push,
   input  logic [FRAME_WIDTH-1:0]            push_frame,
   input  logic                              pop,
   output logic [POP_FRAMES*FRAME_WIDTH-1:0] pop_frames,
   output logic [$clog2(DEPTH):0]            level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] POP_LEVEL = (AW+1)'(POP_FRAMES);

   logic [FRAME_WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          rd_ptr_r;
   logic [AW:0]            level_r;
   logic                   pop_s;

   assign pop_s = pop && (level_r >= POP_LEVEL);
   assign level = level_r;

   // Read window: the POP_FRAMES oldest frames, oldest at the LSB end
   always_comb begin
      pop_frames = '0;
      for (int k = 0; k < POP_FRAMES; k++) begin
         pop_frames[k*FRAME_WIDTH +: FRAME_WIDTH] = mem_r[rd_ptr_r + AW'(k)];
      end
   end

   // Frame storage write port
   always_ff @(posedge clk_pixel) begin
      if (push) mem_r[wr_ptr_r] <= push_frame;
   end

   // Pointers and fill level; a push and a pop in one cycle net out
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(POP_FRAMES);
         level_r <= level_r + (push ? (AW+1)'(1) : (AW+1)'(0)) - (pop_s ? POP_LEVEL : (AW+1)'(0));
      end
   end

endmodule

// File: rtl/packet_scheduler.sv
// HDMI data-island packet chooser: ACR > audio sample > InfoFrames > null, one decision per packet slot.
// Optional: PACKET_SCHEDULER_STARVE_GUARD_EN promotes long-pending InfoFrames above audio.
module packet_scheduler
   import hdmi_packet_pkg::*;
#(
   parameter int                          AUDIO_CHANNELS    = 2,
   parameter int                          AUDIO_BIT_WIDTH   = 16,
   parameter int                          SAMPLE_FIFO_DEPTH = 8,
   parameter int                          NUM_INFOFRAMES    = 5,
   parameter logic [NUM_INFOFRAMES*8-1:0] INFOFRAME_TYPES   = {PKT_VSIF, PKT_EMP, PKT_SPD, PKT_AVI, PKT_AUDIO_IF},
   parameter logic [NUM_INFOFRAMES*4-1:0] INFOFRAME_PERIOD  = {NUM_INFOFRAMES{4'd1}}
) (
   input  logic                                      clk_pixel,
   input  logic                                      reset,
   input  logic                                      video_field_end,
   input  logic                                      packet_enable,
   input  logic [4:0]                                packet_pixel_counter,
   input  logic                                      clk_audio_counter_wrap,
   input  logic                                      audio_sample_valid,
   output logic                                      audio_sample_ready,
   input  logic [AUDIO_CHANNELS*AUDIO_BIT_WIDTH-1:0] audio_sample_word,
   output logic [7:0]                                packet_type,
   output asp_payload_t                              audio_sample_payload,
   output logic [3:0]                                audio_sample_present,
   output logic                                      audio_layout,
   output logic [7:0]                                frame_counter,
   output logic                                      audio_sample_dropped
);

   localparam int SPP = spp_f(AUDIO_CHANNELS);
   localparam int FW  = AUDIO_CHANNELS * AUDIO_BIT_WIDTH;
   localparam int LW  = $clog2(SAMPLE_FIFO_DEPTH) + 1;
   localparam int IW  = (NUM_INFOFRAMES > 1) ? $clog2(NUM_INFOFRAMES) : 1;

   if (!(AUDIO_CHANNELS == 2 || AUDIO_CHANNELS == 8) || AUDIO_BIT_WIDTH < 16 || AUDIO_BIT_WIDTH > 24) begin : g_bad_audio_cfg
      $error("packet_scheduler: AUDIO_CHANNELS must be 2 or 8 and AUDIO_BIT_WIDTH 16..24");
   end

   logic [LW-1:0]             level_s;
   logic [SPP*FW-1:0]         fifo_frames_s;
   logic                      ready_s, push_s, pop_s;
   asp_payload_t              asp_data_s;
   logic                      acr_pend_s, asp_rdy_s;
   logic                      last_wrap_r, wrap_armed_r;
   logic [NUM_INFOFRAMES-1:0] if_pending_r, if_set_s, if_clear_s;
   logic [3:0]                field_cnt_r [NUM_INFOFRAMES];
   logic                      if_hit_s, starve_hit_s;
   logic [IW-1:0]             if_idx_s, starve_idx_s, sel_idx_s;
   logic [7:0]                if_type_s, starve_type_s, sel_type_s;
   logic                      sel_acr_s, sel_asp_s, sel_if_s;
   logic [8:0]                fc_sum_s;
   logic [7:0]                fc_next_s;
   logic [7:0]                packet_type_r, frame_counter_r;
   asp_payload_t              payload_r;
   logic [3:0]                present_r;
   logic                      dropped_r;

   // A pop frees room for a same-cycle push, so ready stays high on a full FIFO being drained
   assign pop_s      = packet_enable && sel_asp_s;
   assign ready_s    = (level_s != LW'(SAMPLE_FIFO_DEPTH)) || pop_s;
   assign push_s     = audio_sample_valid && ready_s;
   assign asp_rdy_s  = level_s >= LW'(SPP);
   assign acr_pend_s = wrap_armed_r && (clk_audio_counter_wrap != last_wrap_r);

   audio_sample_fifo #(
      .FRAME_WIDTH (FW),
      .DEPTH       (SAMPLE_FIFO_DEPTH),
      .POP_FRAMES  (SPP)
   ) u_fifo (
      .clk_pixel  (clk_pixel),
      .reset      (reset),
      .push       (push_s),
      .push_frame (audio_sample_word),
      .pop        (pop_s),
      .pop_frames (fifo_frames_s),
      .level      (level_s)
   );

   // Left-justify each sample into its 24-bit slot; frame-major order gives ch k -> subpacket k/2 in layout 1
   always_comb begin
      asp_data_s = '0;
      for (int n = 0; n < SPP*AUDIO_CHANNELS; n++) begin
         asp_data_s[n*24 +: 24] = 24'(fifo_frames_s[n*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]) << (24 - AUDIO_BIT_WIDTH);
      end
   end

   // Lowest-index pending InfoFrame and per-source period/clear strobes
   always_comb begin
      if_hit_s   = 1'b0;
      if_idx_s   = '0;
      if_type_s  = PKT_NULL;
      if_set_s   = '0;
      if_clear_s = '0;
      for (int i = NUM_INFOFRAMES-1; i >= 0; i--) begin
         if_hit_s  = if_hit_s | if_pending_r[i];
         if_idx_s  = if_pending_r[i] ? IW'(i) : if_idx_s;
         if_type_s = if_pending_r[i] ? INFOFRAME_TYPES[i*8 +: 8] : if_type_s;
      end
      for (int i = 0; i < NUM_INFOFRAMES; i++) begin
         if_set_s[i]   = video_field_end && ((field_cnt_r[i] + 4'd1) == INFOFRAME_PERIOD[i*4 +: 4]);
         if_clear_s[i] = packet_enable && sel_if_s && (sel_idx_s == IW'(i));
      end
   end

`ifdef PACKET_SCHEDULER_STARVE_GUARD_EN
   logic [1:0] starve_cnt_r [NUM_INFOFRAMES];

   // Count field ends seen while a source stays pending; saturates at 2
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_INFOFRAMES; i++) starve_cnt_r[i] <= 2'd0;
      end else begin
         for (int i = 0; i < NUM_INFOFRAMES; i++) begin
            if (if_clear_s[i] && !if_set_s[i]) starve_cnt_r[i] <= 2'd0;
            else if (video_field_end && if_pending_r[i] && (starve_cnt_r[i] != 2'd2)) starve_cnt_r[i] <= starve_cnt_r[i] + 2'd1;
         end
      end
   end

   // Lowest-index starved source
   always_comb begin
      starve_hit_s  = 1'b0;
      starve_idx_s  = '0;
      starve_type_s = PKT_NULL;
      for (int i = NUM_INFOFRAMES-1; i >= 0; i--) begin
         starve_hit_s  = starve_hit_s | (if_pending_r[i] && (starve_cnt_r[i] == 2'd2));
         starve_idx_s  = (if_pending_r[i] && (starve_cnt_r[i] == 2'd2)) ? IW'(i) : starve_idx_s;
         starve_type_s = (if_pending_r[i] && (starve_cnt_r[i] == 2'd2)) ? INFOFRAME_TYPES[i*8 +: 8] : starve_type_s;
      end
   end
`else
   assign starve_hit_s  = 1'b0;
   assign starve_idx_s  = '0;
   assign starve_type_s = PKT_NULL;
`endif

   // Packet arbiter
   always_comb begin
      sel_type_s = PKT_NULL;
      sel_acr_s  = 1'b0;
      sel_asp_s  = 1'b0;
      sel_if_s   = 1'b0;
      sel_idx_s  = '0;
      if (acr_pend_s) begin
         sel_type_s = PKT_ACR;
         sel_acr_s  = 1'b1;
      end else if (starve_hit_s) begin
         sel_type_s = starve_type_s;
         sel_if_s   = 1'b1;
         sel_idx_s  = starve_idx_s;
      end else if (asp_rdy_s) begin
         sel_type_s = PKT_ASP;
         sel_asp_s  = 1'b1;
      end else if (if_hit_s) begin
         sel_type_s = if_type_s;
         sel_if_s   = 1'b1;
         sel_idx_s  = if_idx_s;
      end else begin
         sel_type_s = PKT_NULL;
      end
   end

   // InfoFrame field counters and pending flags; a new period beats a same-cycle clear
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_INFOFRAMES; i++) field_cnt_r[i] <= 4'd0;
         if_pending_r <= '1;
      end else begin
         for (int i = 0; i < NUM_INFOFRAMES; i++) begin
            if (if_set_s[i]) field_cnt_r[i] <= 4'd0;
            else if (video_field_end) field_cnt_r[i] <= field_cnt_r[i] + 4'd1;
         end
         if_pending_r <= if_set_s | (if_pending_r & ~if_clear_s);
      end
   end

   // ACR edge tracking: the first cycle after reset captures the current wrap level
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         wrap_armed_r <= 1'b0;
         last_wrap_r  <= 1'b0;
      end else if (!wrap_armed_r) begin
         wrap_armed_r <= 1'b1;
         last_wrap_r  <= clk_audio_counter_wrap;
      end else if (packet_enable && sel_acr_s) begin
         last_wrap_r  <= clk_audio_counter_wrap;
      end
   end

   // Registered selection, held until the next packet slot
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         packet_type_r <= PKT_NULL;
         payload_r     <= '0;
         present_r     <= 4'b0000;
      end else if (packet_enable) begin
         packet_type_r <= sel_type_s;
         payload_r     <= sel_asp_s ? asp_data_s : '0;
         present_r     <= sel_asp_s ? 4'b1111 : 4'b0000;
      end
   end

   // IEC 60958 frame index advance, modulo 192
   always_comb begin
      fc_sum_s = {1'b0, frame_counter_r} + 9'(SPP);
      if (fc_sum_s >= 9'd192) fc_next_s = 8'(fc_sum_s - 9'd192);
      else fc_next_s = fc_sum_s[7:0];
   end

   // Frame counter and sticky overflow flag
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         frame_counter_r <= 8'd0;
         dropped_r       <= 1'b0;
      end else begin
         if ((packet_pixel_counter == 5'd31) && (packet_type_r == PKT_ASP)) frame_counter_r <= fc_next_s;
         dropped_r <= dropped_r | (audio_sample_valid && !ready_s);
      end
   end

   assign packet_type          = packet_type_r;
   assign audio_sample_payload = payload_r;
   assign audio_sample_present = present_r;
   assign audio_sample_ready   = ready_s;
   assign audio_layout         = (AUDIO_CHANNELS == 8) ? 1'b1 : 1'b0;
   assign frame_counter        = frame_counter_r;
   assign audio_sample_dropped = dropped_r;

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed self-checking bench: a 2ch scheduler and an 8ch scheduler (source 0 period 2) on shared stimulus.
module tb_packet_scheduler;
   import hdmi_packet_pkg::*;

   logic         clk_pixel = 1'b0;
   logic         reset;
   logic         video_field_end, packet_enable, clk_audio_counter_wrap, audio_sample_valid;
   logic [4:0]   packet_pixel_counter;
   logic [31:0]  word2;
   logic [127:0] word8;

   logic         a_ready, a_layout, a_dropped, b_ready, b_layout, b_dropped;
   logic [7:0]   a_type, a_fc, b_type, b_fc;
   logic [191:0] a_payload, b_payload;
   logic [3:0]   a_present, b_present;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_pixel = ~clk_pixel;

   packet_scheduler u_dut2 (
      .clk_pixel(clk_pixel), .reset(reset), .video_field_end(video_field_end),
      .packet_enable(packet_enable), .packet_pixel_counter(packet_pixel_counter),
      .clk_audio_counter_wrap(clk_audio_counter_wrap), .audio_sample_valid(audio_sample_valid),
      .audio_sample_ready(a_ready), .audio_sample_word(word2), .packet_type(a_type),
      .audio_sample_payload(a_payload), .audio_sample_present(a_present), .audio_layout(a_layout),
      .frame_counter(a_fc), .audio_sample_dropped(a_dropped)
   );

   packet_scheduler #(
      .AUDIO_CHANNELS(8),
      .INFOFRAME_PERIOD({4'd1, 4'd1, 4'd1, 4'd1, 4'd2})
   ) u_dut8 (
      .clk_pixel(clk_pixel), .reset(reset), .video_field_end(video_field_end),
      .packet_enable(packet_enable), .packet_pixel_counter(packet_pixel_counter),
      .clk_audio_counter_wrap(clk_audio_counter_wrap), .audio_sample_valid(audio_sample_valid),
      .audio_sample_ready(b_ready), .audio_sample_word(word8), .packet_type(b_type),
      .audio_sample_payload(b_payload), .audio_sample_present(b_present), .audio_layout(b_layout),
      .frame_counter(b_fc), .audio_sample_dropped(b_dropped)
   );

   function automatic logic [15:0] s2(input int n);
      return 16'h1000 + 16'(n * 257);
   endfunction

   function automatic logic [31:0] frame2(input int f);
      return {s2(2*f+1), s2(2*f)};
   endfunction

   function automatic logic [191:0] exp2(input int f0);
      logic [191:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[k*24 +: 24] = {s2(2*f0+k), 8'h00};
      return r;
   endfunction

   function automatic logic [15:0] s8(input int n);
      return 16'h2000 + 16'(n * 273);
   endfunction

   function automatic logic [127:0] frame8(input int f);
      logic [127:0] r;
      for (int k = 0; k < 8; k++) r[k*16 +: 16] = s8(8*f+k);
      return r;
   endfunction

   function automatic logic [191:0] exp8(input int f);
      logic [191:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[k*24 +: 24] = {s8(8*f+k), 8'h00};
      return r;
   endfunction

   task automatic tick;
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input int f);
      audio_sample_valid = 1'b1;
      word2 = frame2(f);
      word8 = frame8(f);
      tick;
      audio_sample_valid = 1'b0;
   endtask

   task automatic enable_pkt;
      packet_enable = 1'b1;
      tick;
      packet_enable = 1'b0;
   endtask

   task automatic field_pulse;
      video_field_end = 1'b1;
      tick;
      video_field_end = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      video_field_end = 1'b0;
      packet_enable = 1'b0;
      packet_pixel_counter = 5'd0;
      clk_audio_counter_wrap = 1'b0;
      audio_sample_valid = 1'b0;
      tick;
      tick;
      reset = 1'b0;
      tick;
   endtask

   initial begin
      logic [7:0] ord_a  [6] = '{8'h84, 8'h82, 8'h83, 8'h7F, 8'h81, 8'h00};
      logic [7:0] ord_b2 [6] = '{8'h82, 8'h83, 8'h7F, 8'h81, 8'h00, 8'h00};
      int f;

      word2 = '0;
      word8 = '0;
      reset = 1'b1;
      video_field_end = 1'b0;
      packet_enable = 1'b0;
      packet_pixel_counter = 5'd0;
      clk_audio_counter_wrap = 1'b0;
      audio_sample_valid = 1'b0;
      tick;
      tick;
      check("rst_type", a_type, 8'h00);
      check("rst_payload", a_payload, 192'd0);
      check("rst_present", a_present, 4'b0000);
      check("rst_fc", a_fc, 8'd0);
      check("rst_ready", a_ready, 1'b1);
      check("rst_dropped", a_dropped, 1'b0);
      check("layout_2ch", a_layout, 1'b0);
      check("layout_8ch", b_layout, 1'b1);
      check("rst_ready_8ch", b_ready, 1'b1);
      check("rst_dropped_8ch", b_dropped, 1'b0);
      reset = 1'b0;
      tick;

      // InfoFrame rotation, then per-source periods
      for (int i = 0; i < 6; i++) begin
         enable_pkt;
         check("if_order_a", a_type, ord_a[i]);
         check("if_order_b", b_type, ord_a[i]);
      end
      field_pulse;
      for (int i = 0; i < 6; i++) begin
         enable_pkt;
         check("if_p1_a", a_type, ord_a[i]);
         check("if_p2_b", b_type, ord_b2[i]);
      end
      field_pulse;
      enable_pkt;
      check("if_field2_a", a_type, 8'h84);
      check("if_field2_b", b_type, 8'h84);

      // ACR beats ASP, ASP next, then null; a double toggle yields no ACR
      do_reset;
      for (int i = 0; i < 5; i++) enable_pkt;
      clk_audio_counter_wrap = 1'b1;
      for (int i = 0; i < 4; i++) push(i);
      enable_pkt;
      check("acr_first", a_type, 8'h01);
      enable_pkt;
      check("asp_second", a_type, 8'h02);
      check("asp_payload0", a_payload, exp2(0));
      check("asp_present", a_present, 4'b1111);
      enable_pkt;
      check("null_third", a_type, 8'h00);
      check("null_present", a_present, 4'b0000);
      clk_audio_counter_wrap = 1'b0;
      tick;
      clk_audio_counter_wrap = 1'b1;
      tick;
      enable_pkt;
      check("acr_double_toggle", a_type, 8'h00);

      // Plain 2ch ASP; FIFO empties so the next slot is null
      for (int i = 4; i < 8; i++) push(i);
      enable_pkt;
      check("asp2_type", a_type, 8'h02);
      check("asp2_payload", a_payload, exp2(4));
      enable_pkt;
      check("asp2_drained", a_type, 8'h00);

      // Full FIFO, sticky drop, push + pop at full
      do_reset;
      for (f = 0; f < 8; f++) begin
         audio_sample_valid = 1'b1;
         word2 = frame2(f);
         word8 = frame8(f);
         tick;
      end
      check("full_ready", a_ready, 1'b0);
      word2 = frame2(8);
      word8 = frame8(8);
      tick;
      check("dropped_set", a_dropped, 1'b1);
      packet_enable = 1'b1;
      tick;
      packet_enable = 1'b0;
      audio_sample_valid = 1'b0;
      check("full_pop_type", a_type, 8'h02);
      check("full_pop_payload", a_payload, exp2(0));
      check("ready_after_pop", a_ready, 1'b1);
      enable_pkt;
      check("pop2_payload", a_payload, exp2(4));
      for (int i = 9; i < 12; i++) push(i);
      enable_pkt;
      check("level5_type", a_type, 8'h02);
      check("level5_payload", a_payload, exp2(8));
      check("dropped_sticky", a_dropped, 1'b1);

      // Asynchronous reset in the middle of an ASP slot with a full FIFO
      for (int i = 12; i < 20; i++) push(i);
      check("refill_ready", a_ready, 1'b0);
      enable_pkt;
      for (int i = 20; i < 24; i++) push(i);
      check("refull_ready", a_ready, 1'b0);
      check("pre_reset_type", a_type, 8'h02);
      #3;
      reset = 1'b1;
      #1;
      check("async_rst_type", a_type, 8'h00);
      check("async_rst_ready", a_ready, 1'b1);
      check("async_rst_present", a_present, 4'b0000);
      check("async_rst_dropped", a_dropped, 1'b0);
      tick;
      reset = 1'b0;
      tick;
      enable_pkt;
      check("audio_discarded", a_type, 8'h84);

      // 2ch frame counter: 4 per packet, 188 -> 0
      do_reset;
      f = 0;
      for (int p = 1; p <= 48; p++) begin
         for (int i = 0; i < 4; i++) begin
            push(f);
            f++;
         end
         enable_pkt;
         packet_pixel_counter = 5'd31;
         tick;
         packet_pixel_counter = 5'd0;
         if (p == 1) check("fc2_first", a_fc, 8'd4);
         if (p == 47) check("fc2_188", a_fc, 8'd188);
         if (p == 48) check("fc2_wrap", a_fc, 8'd0);
      end

      // 8ch frame counter: 1 per packet, 191 -> 0
      do_reset;
      for (int p = 1; p <= 192; p++) begin
         push(p - 1);
         enable_pkt;
         if (p == 1) begin
            check("asp8_type", b_type, 8'h02);
            check("asp8_present", b_present, 4'b1111);
            check("asp8_payload", b_payload, exp8(0));
         end
         packet_pixel_counter = 5'd31;
         tick;
         packet_pixel_counter = 5'd0;
         if (p == 1) check("fc8_first", b_fc, 8'd1);
         if (p == 48) check("fc8_48", b_fc, 8'd48);
         if (p == 191) check("fc8_191", b_fc, 8'd191);
         if (p == 192) check("fc8_wrap", b_fc, 8'd0);
      end
      enable_pkt;
      check("if_after_audio_8ch", b_type, 8'h84);
      packet_pixel_counter = 5'd31;
      tick;
      packet_pixel_counter = 5'd0;
      check("fc8_hold_non_asp", b_fc, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
